// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of operand-ready RS entries through one shared ALU onto the CDB.
// A grant is taken from IDLE, or from WB in the cycle the CDB accepts, so ops can run back to back.
module alu_issue_arbiter #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic [ENTRIES-1:0] req_valid,
  input  logic [XLEN-1:0]    sel_lv,
  input  logic [XLEN-1:0]    sel_rv,
  input  logic [3:0]         sel_op,
  input  logic [TAG_W-1:0]   sel_tag,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               alu_valid,
  output logic [XLEN-1:0]    alu_lv,
  output logic [XLEN-1:0]    alu_rv,
  output logic [3:0]         alu_op,
  input  logic               alu_done,
  input  logic [XLEN-1:0]    alu_result,
  output logic               cdb_valid,
  output logic [TAG_W-1:0]   cdb_tag,
  output logic [XLEN-1:0]    cdb_value,
  input  logic               cdb_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               alu_valid_q, alu_valid_d;
  logic [XLEN-1:0]    alu_lv_q, alu_lv_d;
  logic [XLEN-1:0]    alu_rv_q, alu_rv_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]    cdb_value_q, cdb_value_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               issue_ok;

  // First requesting entry at or after rr_ptr, wrapping around the array.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % ENTRIES);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign issue_ok = !rst && rdy && !flush && sel_found &&
                    (state_q == IDLE || (state_q == WB && cdb_ready));

  assign grant_valid = issue_ok;
  assign grant_idx   = issue_ok ? sel_idx : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tag_d       = tag_q;
    alu_valid_d = alu_valid_q;
    alu_lv_d    = alu_lv_q;
    alu_rv_d    = alu_rv_q;
    alu_op_d    = alu_op_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    if (rdy) begin
      if (flush) begin
        state_d     = IDLE;
        alu_valid_d = 1'b0;
        cdb_valid_d = 1'b0;
      end else begin
        case (state_q)
          EXEC: begin
            if (alu_done) begin
              cdb_value_d = alu_result;
              cdb_tag_d   = tag_q;
              cdb_valid_d = 1'b1;
              alu_valid_d = 1'b0;
              state_d     = WB;
            end
          end
          WB: begin
            if (cdb_ready) begin
              cdb_valid_d = 1'b0;
              state_d     = IDLE;
            end
          end
          default: ;
        endcase
        // A grant out of WB overrides the return to IDLE.
        if (issue_ok) begin
          alu_lv_d    = sel_lv;
          alu_rv_d    = sel_rv;
          alu_op_d    = sel_op;
          tag_d       = sel_tag;
          alu_valid_d = 1'b1;
          rr_ptr_d    = IDX_W'((int'(sel_idx) + 1) % ENTRIES);
          state_d     = EXEC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      tag_q       <= '0;
      alu_valid_q <= 1'b0;
      alu_lv_q    <= '0;
      alu_rv_q    <= '0;
      alu_op_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_q       <= tag_d;
      alu_valid_q <= alu_valid_d;
      alu_lv_q    <= alu_lv_d;
      alu_rv_q    <= alu_rv_d;
      alu_op_q    <= alu_op_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_lv    = alu_lv_q;
  assign alu_rv    = alu_rv_q;
  assign alu_op    = alu_op_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Selects one operand-ready reservation-station entry per issue slot, using round-robin order. It sequences that entry through the single shared ALU and presents the result on the common data bus (CDB) with its ROB tag. It sits between the RS entry array and the ALU/CDB. It replaces ad-hoc in-RS ALU driving with a handshaked, flush-aware controller.

## Interface
- ENTRIES, 16, number of RS entries arbitrated
- IDX_W, 4, log2(ENTRIES)
- TAG_W, 4, ROB tag width
- XLEN, 32, datapath width
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction clear; aborts in-flight op
- req_valid  in  ENTRIES  bit i = RS entry i busy with both operands resolved
- sel_lv, sel_rv  in  XLEN  operands of entry grant_idx (RS muxes combinationally)
- sel_op  in  4  ALU opcode of entry grant_idx
- sel_tag  in  TAG_W  ROB tag of entry grant_idx
- grant_valid  out  1  combinational; entry grant_idx is taken this cycle, so RS clears its ready flag at posedge
- grant_idx  out  IDX_W  combinational; selected entry
- alu_valid  out  1  request to ALU, held until alu_done
- alu_lv, alu_rv  out  XLEN  registered operands
- alu_op  out  4  registered opcode
- alu_done  in  1  ALU result valid (one-cycle pulse)
- alu_result  in  XLEN  ALU result
- cdb_valid  out  1  result broadcast request, held until cdb_ready
- cdb_tag  out  TAG_W  ROB tag of result
- cdb_value  out  XLEN  result value
- cdb_ready  in  1  CDB owner accepts broadcast this cycle
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, WB. Reset: IDLE; rr_ptr=0; all registered outputs 0.
- Selection: the first set bit of req_valid, scanning rr_ptr, rr_ptr+1, … ENTRIES-1, 0, … with wrap.
- issue_ok = rdy & !flush & |req_valid & (state==IDLE | (state==WB & cdb_ready)).
- grant_valid = issue_ok.
- grant_idx = the selected index when granting; 0 when not granting.
- On grant (posedge):
  - alu_lv/alu_rv/alu_op <= sel_*.
  - Internal tag register <= sel_tag.
  - alu_valid <= 1.
  - rr_ptr <= (grant_idx+1) mod ENTRIES.
  - state <= EXEC.
- EXEC: on alu_done, the block captures alu_result into cdb_value, cdb_tag <= tag, cdb_valid <= 1, alu_valid <= 0, state <= WB.
- WB: cdb_valid/tag/value are held stable until cdb_ready.
  - On cdb_ready: cdb_valid <= 0 and state <= IDLE.
  - If issue_ok in the same cycle, the new grant is taken instead and state <= EXEC. This gives back-to-back operation.
- alu_done is sampled only in EXEC; it is ignored in IDLE/WB.
- cdb_ready is sampled only in WB.
- flush (rdy high): from any state, state <= IDLE, alu_valid <= 0, cdb_valid <= 0, no grant. Any alu_done in the flush cycle is discarded. rr_ptr is unchanged. The ALU aborts its op when alu_valid falls.
- rdy low: no state, pointer or output register changes. grant_valid=0. alu_done/cdb_ready/flush are not sampled; the ALU is frozen by the same rdy.
- Priority: rst > rdy low > flush > normal operation.

## Timing
- Grant cycle N → alu_valid high at N+1. The ALU may pulse alu_done at N+1 at the earliest.
- alu_done at cycle M → cdb_valid high at M+1.
- Minimum per-op occupancy is 3 cycles. Steady state with cdb_ready tied high and a 1-cycle ALU: one grant every 2 cycles.
- grant_valid never asserts in EXEC.
- Reset mid-operation: next cycle IDLE with all outputs 0, identical to power-on reset.

## Test plan
- Reset: hold rst 2 cycles with req_valid=0xFFFF → grant_valid=0, alu_valid=0, cdb_valid=0, busy=0.
- Single op: req_valid=0x0020, sel_lv=7, sel_rv=3, sel_tag=9, Add; alu_done at the next cycle with result 10.
  - grant_idx=5 at cycle 0.
  - alu_valid, lv=7, rv=3 at cycle 1.
  - cdb_valid, tag=9, value=10 at cycle 2.
- Round-robin with wrap: req_valid=0x8011 held, instant ALU, cdb_ready=1 → grant order 0, 4, 15, 0, 4.
- CDB backpressure: cdb_ready=0 for 3 WB cycles with other requests pending.
  - cdb_tag/value stay stable and there is no grant.
  - The cycle cdb_ready rises, grant_valid=1 and state goes WB→EXEC.
- Flush in EXEC coincident with alu_done → no cdb_valid, state IDLE, alu_valid=0 next cycle; the next grant follows rr_ptr.
- rdy low for 4 cycles in EXEC with alu_done pulsed during the freeze → outputs frozen and the pulse is ignored; the op completes on the alu_done pulse after rdy returns.
